// File: rtl/perf_counter_dump.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : perf_counter_dump                                             |
// | Snapshots the counter bank on request and streams (id, value) records  |
// | over valid/ready. Optional macro PERF_DUMP_CHECKSUM_EN appends an XOR  |
// | checksum record.                                                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module perf_counter_dump #(
  parameter int NUM_CTRS     = 9,
  parameter int CTR_W        = 32,
  parameter int ID_W         = 4,
  parameter int CYCLE_ADJUST = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CTRS*CTR_W-1:0] ctr_in,
  input  logic                      dump_req,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic [CTR_W-1:0]          out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int NUM_REC = NUM_CTRS + 1;
`else
  localparam int NUM_REC = NUM_CTRS;
`endif

  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REC - 1);
  localparam logic [CTR_W-1:0] ADJ      = CTR_W'(CYCLE_ADJUST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [CTR_W-1:0]  shadow_q [NUM_REC];
  logic [CTR_W-1:0]  shadow_d [NUM_REC];
  logic [CTR_W-1:0]  snap     [NUM_REC];
  logic [CTR_W-1:0]  c0_raw;

  assign c0_raw = ctr_in[0 +: CTR_W];

  // Counter 0 loses the measurement overhead, but never wraps below it.
  always_comb begin
    for (int k = 0; k < NUM_REC; k++) begin
      snap[k] = '0;
    end
    snap[0] = (c0_raw > ADJ) ? (c0_raw - ADJ) : c0_raw;
    for (int k = 1; k < NUM_CTRS; k++) begin
      snap[k] = ctr_in[k*CTR_W +: CTR_W];
    end
`ifdef PERF_DUMP_CHECKSUM_EN
    for (int k = 0; k < NUM_CTRS; k++) begin
      snap[NUM_CTRS] = snap[NUM_CTRS] ^ snap[k];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          shadow_d = snap;
          idx_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NUM_REC; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Record fields are gated so the bus reads all-zero outside SEND.
  always_comb begin
    out_valid = (state_q == S_SEND);
    busy      = (state_q == S_SEND);
    done      = (state_q == S_DONE);
    out_id    = '0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == S_SEND) begin
      out_id   = idx_q;
      out_data = shadow_q[idx_q];
      out_last = (idx_q == LAST_IDX);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_dump.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_perf_counter_dump                                          |
// | Scoreboard bench for perf_counter_dump (honours PERF_DUMP_CHECKSUM_EN).|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_perf_counter_dump;

  localparam int NUM_CTRS = 9;
  localparam int CTR_W    = 32;
  localparam int ID_W     = 4;
  localparam int ADJ      = 10;
`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int NREC = NUM_CTRS + 1;
`else
  localparam int NREC = NUM_CTRS;
`endif

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CTR_W-1:0] data;
    logic             last;
  } rec_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CTRS*CTR_W-1:0] ctr_in;
  logic                      dump_req;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           out_id;
  logic [CTR_W-1:0]          out_data;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  rec_t sb [$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  perf_counter_dump #(
    .NUM_CTRS(NUM_CTRS), .CTR_W(CTR_W), .ID_W(ID_W), .CYCLE_ADJUST(ADJ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctr_in(ctr_in), .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CTR_W-1:0] adjust(input logic [CTR_W-1:0] v);
    return (v > CTR_W'(ADJ)) ? v - CTR_W'(ADJ) : v;
  endfunction

  task automatic push_expected(input logic [CTR_W-1:0] c [NUM_CTRS]);
    rec_t             r;
    logic [CTR_W-1:0] csum;
    csum = '0;
    for (int k = 0; k < NUM_CTRS; k++) begin
      r.id   = ID_W'(k);
      r.data = (k == 0) ? adjust(c[0]) : c[k];
      r.last = (k == NREC - 1);
      csum   = csum ^ r.data;
      sb.push_back(r);
    end
`ifdef PERF_DUMP_CHECKSUM_EN
    r.id   = ID_W'(NUM_CTRS);
    r.data = csum;
    r.last = 1'b1;
    sb.push_back(r);
`endif
  endtask

  task automatic load_ctrs(input logic [CTR_W-1:0] c [NUM_CTRS]);
    for (int k = 0; k < NUM_CTRS; k++) begin
      ctr_in[k*CTR_W +: CTR_W] = c[k];
    end
  endtask

  // Monitor: pops on every transfer and checks the record is held across stalls.
  logic pend = 1'b0;
  rec_t held;
  rec_t cur;
  rec_t exp_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      cur = {out_id, out_data, out_last};
      if (pend) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'(cur), 64'(held));
      end
      if (out_valid) begin
        if (out_ready) begin
          check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            check("record", 64'(cur), 64'(exp_r));
          end
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = cur;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic run_dump(input logic [CTR_W-1:0] c [NUM_CTRS], input bit rnd, input bit disturb);
    int n;
    bit got;
    load_ctrs(c);
    push_expected(c);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    dump_req  = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        if (disturb && n == 4) begin
          ctr_in   = ~ctr_in;
          dump_req = 1'b1;
        end
        if (disturb && n == 5) dump_req = 1'b0;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    if (!rnd) check("dump_latency", 64'(n), 64'(NREC + 1));
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("idle_after_dump", 64'({out_valid, busy}), 64'd0);
  endtask

  logic [CTR_W-1:0] c2 [NUM_CTRS];
  logic [CTR_W-1:0] cv [NUM_CTRS];
  logic [CTR_W-1:0] c0_cases [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b1;
    ctr_in    = '0;
    c2        = '{32'd100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    c0_cases  = '{32'd7, 32'd10, 32'd11, 32'hFFFF_FFFF};
    #2;
    check("reset_outputs", 64'({out_valid, out_id, out_data, out_last, busy, done}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'({out_valid, out_id, out_data, out_last, busy, done}), 64'd0);

    // Reference dump with the sink always ready.
    @(posedge clk); #1;
    run_dump(c2, 1'b0, 1'b0);

    // Counter-0 overhead boundary around CYCLE_ADJUST and at the top of range.
    for (int i = 0; i < 4; i++) begin
      cv[0] = c0_cases[i];
      for (int k = 1; k < NUM_CTRS; k++) cv[k] = $urandom;
      @(posedge clk); #1;
      run_dump(cv, 1'b0, 1'b0);
    end

    // Random backpressure.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NUM_CTRS; k++) cv[k] = $urandom;
      @(posedge clk); #1;
      run_dump(cv, 1'b1, 1'b0);
    end

    // Inputs move and dump_req pulses mid-dump: snapshot must win, no re-trigger.
    for (int k = 0; k < NUM_CTRS; k++) cv[k] = $urandom;
    @(posedge clk); #1;
    run_dump(cv, 1'b0, 1'b1);

    // Asynchronous reset while idle.
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("reset_mid_idle", 64'({out_valid, out_id, out_data, out_last, busy, done}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset while streaming, with the sink stalled.
    @(posedge clk); #1;
    load_ctrs(c2);
    push_expected(c2);
    out_ready = 1'b1;
    dump_req  = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("send_before_reset", 64'({out_valid, busy}), 64'd3);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_send", 64'({out_valid, out_id, out_data, out_last, busy, done}), 64'd0);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_dump(c2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
